// File: rtl/krnl_vadd_rtl_splitter.sv
// Broadcast splitter: every accepted input word is copied into one small FIFO per
// output channel, so each consumer can stall on its own without losing data.
module krnl_vadd_rtl_splitter #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_FIFO_DEPTH   = 2
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  input  logic [C_DATA_WIDTH-1:0]                s_tdata,
  output logic [C_NUM_CHANNELS-1:0]              m_tvalid,
  input  logic [C_NUM_CHANNELS-1:0]              m_tready,
  output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] m_tdata
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(C_FIFO_DEPTH);

  logic [C_DATA_WIDTH-1:0] mem [C_NUM_CHANNELS][C_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr [C_NUM_CHANNELS];
  logic [CW-1:0]           count  [C_NUM_CHANNELS];
  logic                    room;
  logic                    push;
  logic [C_NUM_CHANNELS-1:0] pop;

  // Input is accepted only when every channel has a free slot, judged from registered counts.
  always_comb begin
    room = 1'b1;
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      if (count[i] >= FULL) room = 1'b0;
    end
  end

  assign s_tready = ~areset & room;
  assign push     = s_tvalid & s_tready;

  always_comb begin
    m_tvalid = '0;
    m_tdata  = '0;
    pop      = '0;
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      m_tvalid[i]                            = (count[i] != '0);
      m_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH] = mem[i][rd_ptr[i]];
      pop[i]                                 = m_tvalid[i] & m_tready[i];
    end
  end

  // Storage holds no reset; contents are meaningless while the matching count is zero.
  always_ff @(posedge aclk) begin
    if (push) begin
      for (int i = 0; i < C_NUM_CHANNELS; i++) begin
        mem[i][wr_ptr] <= s_tdata;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      for (int i = 0; i < C_NUM_CHANNELS; i++) begin
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      for (int i = 0; i < C_NUM_CHANNELS; i++) begin
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push, pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

endmodule
